lsu_ctrl: RTL and testbench

- Load/store control stage directly upstream of the byte-addressed data memory.
- Accepts one load/store request at a time from the core datapath, using RISC-V funct3 encoding: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Drives the memory port, sign- or zero-extends load results, and performs read-modify-write for SB/SH, because the memory writes only whole 32-bit words.
- Asserts busy to stall the core while an access is in flight.

---
 rtl/lsu_ctrl_pkg.sv | 22 ++
 rtl/lsu_ctrl_if.sv | 27 ++
 rtl/lsu_ctrl_align.sv | 46 ++++
 rtl/lsu_ctrl.sv | 152 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store control slice.
//   - BUS_WIDTH_DEF : default data/address bus width
//   - F3_*          : RISC-V funct3 access-type encodings
//   - lsu_state_t   : control FSM states
package lsu_pkg;

  localparam int unsigned BUS_WIDTH_DEF = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response bundle of the load/store unit.
//   req_valid/req_we/req_funct3/req_addr/req_wdata : request from the core
//   busy/done/fault/load_data                      : status/result to the core
// Modports: master = core datapath, slave = lsu_ctrl.
interface lsu_ctrl_if #(
  parameter int unsigned BUS_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [BUS_WIDTH-1:0] req_wdata;
  logic                 busy;
  logic                 done;
  logic                 fault;
  logic [BUS_WIDTH-1:0] load_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  busy, done, fault, load_data
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output busy, done, fault, load_data
  );
endinterface

// File: rtl/lsu_ctrl_align.sv
// Combinational data alignment for a big-endian word memory.
//   funct3   in  access type (RISC-V encoding)
//   rdata    in  word read from memory; the addressed byte sits in the MSBs
//   wdata    in  store data; byte/half taken from the LSBs
//   load_ext out extracted and sign/zero-extended load value
//   merged   out read word with the store byte/half overlaid in the MSBs
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF
) (
  input  logic [2:0]           funct3,
  input  logic [BUS_WIDTH-1:0] rdata,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic [BUS_WIDTH-1:0] load_ext,
  output logic [BUS_WIDTH-1:0] merged
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[BUS_WIDTH-1 -: 8];
  assign rd_half = rdata[BUS_WIDTH-1 -: 16];

  always_comb begin
    load_ext = '0;
    unique case (funct3)
      F3_B:    load_ext = {{(BUS_WIDTH-8){rd_byte[7]}}, rd_byte};
      F3_BU:   load_ext = {{(BUS_WIDTH-8){1'b0}}, rd_byte};
      F3_H:    load_ext = {{(BUS_WIDTH-16){rd_half[15]}}, rd_half};
      F3_HU:   load_ext = {{(BUS_WIDTH-16){1'b0}}, rd_half};
      F3_W:    load_ext = rdata;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    merged = wdata;
    unique case (funct3)
      F3_B:    merged = {wdata[7:0], rdata[BUS_WIDTH-9:0]};
      F3_H:    merged = {wdata[15:0], rdata[BUS_WIDTH-17:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of a byte-addressed, word-wide memory.
// Accepts one request at a time, drives the memory port, extends load data
// and performs read-modify-write for sub-word stores.
//   clk, rst_n   clock, asynchronous active-low reset
//   core         lsu_ctrl_if.slave: request in, busy/done/fault/load_data out
//   mem_addr     memory byte address (latched address in ACCESS/WRITE, else 0)
//   mem_wdata    memory write data
//   mem_wr_en    memory write enable (memory commits on negedge)
//   mem_rd_en    memory read enable
//   mem_rdata    combinational memory read data
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int unsigned ADDR_BITS = 11,
  parameter int unsigned DEPTH     = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsu_ctrl_if.slave            core,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  input  logic [BUS_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_BITS-1:0] ADDR_LIMIT = ADDR_BITS'(DEPTH - 4);

  lsu_state_t           state, state_nxt;
  logic [BUS_WIDTH-1:0] addr_r;
  logic [BUS_WIDTH-1:0] wdata_r;
  logic [BUS_WIDTH-1:0] merged_r;
  logic [BUS_WIDTH-1:0] load_data_r;
  logic [2:0]           f3_r;
  logic                 we_r;
  logic                 fault_r;

  logic                 f3_ok;
  logic                 addr_ok;
  logic                 req_bad;
  logic                 sub_word_store;
  logic [BUS_WIDTH-1:0] load_ext;
  logic [BUS_WIDTH-1:0] merged;

  lsu_align #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_align (
    .funct3   (f3_r),
    .rdata    (mem_rdata),
    .wdata    (wdata_r),
    .load_ext (load_ext),
    .merged   (merged)
  );

  // Request legality is judged on the incoming request so a fault can skip
  // straight to RESP on the accepting edge.
  always_comb begin
    if (core.req_we)
      f3_ok = (core.req_funct3 <= F3_W);
    else
      f3_ok = (core.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    addr_ok = (core.req_addr[BUS_WIDTH-1:ADDR_BITS] == '0) &&
              (core.req_addr[ADDR_BITS-1:0] <= ADDR_LIMIT);
    req_bad = !(f3_ok && addr_ok);
  end

  assign sub_word_store = we_r && (f3_r != F3_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Memory port is decoded from registered state only, so enables and
  // address stay stable across the memory's negedge write and drop
  // asynchronously with reset.
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (core.req_valid)
          state_nxt = req_bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_addr = addr_r;
        if (we_r && !sub_word_store) begin
          mem_wr_en = 1'b1;
          mem_wdata = wdata_r;
        end else begin
          mem_rd_en = 1'b1;
        end
        state_nxt = sub_word_store ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_addr  = addr_r;
        mem_wr_en = 1'b1;
        mem_wdata = merged_r;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= '0;
      wdata_r     <= '0;
      merged_r    <= '0;
      load_data_r <= '0;
      f3_r        <= '0;
      we_r        <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (core.req_valid) begin
            addr_r  <= core.req_addr;
            wdata_r <= core.req_wdata;
            f3_r    <= core.req_funct3;
            we_r    <= core.req_we;
            fault_r <= req_bad;
            if (req_bad && !core.req_we)
              load_data_r <= '0;
          end
        end
        ST_ACCESS: begin
          if (!we_r)
            load_data_r <= load_ext;
          else if (sub_word_store)
            merged_r <= merged;
        end
        default: ;
      endcase
    end
  end

  assign core.busy      = (state != ST_IDLE);
  assign core.done      = (state == ST_RESP);
  assign core.fault     = (state == ST_RESP) && fault_r;
  assign core.load_data = load_data_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr_en, mem_rd_en;
  int          cyc = 0;

  lsu_ctrl_if #(.BUS_WIDTH(32)) cif ();

  lsu_ctrl #(
    .BUS_WIDTH (32),
    .ADDR_BITS (11),
    .DEPTH     (2048)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core      (cif.slave),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory seen by the DUT: big-endian, combinational read,
  // whole-word write on negedge.
  logic [7:0] mem_bytes [0:2047];
  // Reference byte image, updated by the model at issue time.
  logic [7:0] ref_mem [0:2047];
  logic [31:0] last_ld;

  always_comb begin
    if (mem_addr <= 32'd2044)
      mem_rdata = {mem_bytes[mem_addr[10:0]], mem_bytes[mem_addr[10:0] + 11'd1],
                   mem_bytes[mem_addr[10:0] + 11'd2], mem_bytes[mem_addr[10:0] + 11'd3]};
    else
      mem_rdata = 32'h0;
  end

  always @(negedge clk) begin
    if (mem_wr_en && mem_addr <= 32'd2044) begin
      mem_bytes[mem_addr[10:0]]         = mem_wdata[31:24];
      mem_bytes[mem_addr[10:0] + 11'd1] = mem_wdata[23:16];
      mem_bytes[mem_addr[10:0] + 11'd2] = mem_wdata[15:8];
      mem_bytes[mem_addr[10:0] + 11'd3] = mem_wdata[7:0];
    end
  end

  typedef struct {
    logic        fault;
    logic [31:0] ld;
    int          lat;
    int          rd;
    int          wr;
    int          acc;
  } exp_t;

  exp_t exq [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: computes the architectural outcome of one request.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    bit          ok_f3, ok_a;
    logic [10:0] i;
    logic [15:0] h;
    ok_f3 = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    ok_a  = (a <= 32'd2044);
    i     = a[10:0];
    e.fault = 1'b0; e.rd = 0; e.wr = 0;
    if (!(ok_f3 && ok_a)) begin
      e.fault = 1'b1; e.lat = 1;
      if (!we) last_ld = 32'h0;
    end else if (!we) begin
      e.lat = 2; e.rd = 1;
      h = {ref_mem[i], ref_mem[i + 11'd1]};
      case (f3)
        3'd0: last_ld = 32'($signed(ref_mem[i]));
        3'd4: last_ld = {24'h0, ref_mem[i]};
        3'd1: last_ld = 32'($signed(h));
        3'd5: last_ld = {16'h0, h};
        default: last_ld = {ref_mem[i], ref_mem[i + 11'd1], ref_mem[i + 11'd2], ref_mem[i + 11'd3]};
      endcase
    end else begin
      e.wr = 1;
      case (f3)
        3'd0: begin e.lat = 3; e.rd = 1; ref_mem[i] = wd[7:0]; end
        3'd1: begin e.lat = 3; e.rd = 1; ref_mem[i] = wd[15:8]; ref_mem[i + 11'd1] = wd[7:0]; end
        default: begin
          e.lat = 2;
          ref_mem[i] = wd[31:24]; ref_mem[i + 11'd1] = wd[23:16];
          ref_mem[i + 11'd2] = wd[15:8]; ref_mem[i + 11'd3] = wd[7:0];
        end
      endcase
    end
    e.ld = last_ld;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50; k++) begin
      if (!cif.busy && !cif.done) break;
      @(posedge clk); #1;
    end
    if (k == 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Present one request for a single accepting edge; expected outcome is
  // pushed for the monitor when push is set.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit push);
    exp_t e;
    wait_idle();
    cif.req_valid  = 1'b1;
    cif.req_we     = we;
    cif.req_funct3 = f3;
    cif.req_addr   = a;
    cif.req_wdata  = wd;
    if (push) begin
      model(we, f3, a, wd, e);
      e.acc = cyc + 1;
      exq.push_back(e);
    end
    @(posedge clk); #1;
    cif.req_valid = 1'b0;
  endtask

  // Monitor: counts enable/busy cycles per transaction and scores on done.
  int   rd_cnt = 0, wr_cnt = 0, busy_cnt = 0;
  exp_t me;
  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      rd_cnt = 0; wr_cnt = 0; busy_cnt = 0;
    end else begin
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) wr_cnt++;
      if (cif.busy)  busy_cnt++;
      if (cif.done) begin
        if (exq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = exq.pop_front();
          chk("fault",     {31'h0, cif.fault}, {31'h0, me.fault});
          chk("load_data", cif.load_data, me.ld);
          chk("latency",   32'(cyc - me.acc + 1), 32'(me.lat));
          chk("busy_cyc",  32'(busy_cnt), 32'(me.lat));
          chk("rd_en_cyc", 32'(rd_cnt), 32'(me.rd));
          chk("wr_en_cyc", 32'(wr_cnt), 32'(me.wr));
        end
        rd_cnt = 0; wr_cnt = 0; busy_cnt = 0;
      end
    end
  end

  initial begin
    int k, bad;
    logic [31:0] a;
    logic [2:0]  f3;
    logic        we;

    for (int i = 0; i < 2048; i++) begin
      mem_bytes[i] = 8'($urandom);
      ref_mem[i]   = mem_bytes[i];
    end
    mem_bytes[16] = 8'h80; mem_bytes[17] = 8'h12; mem_bytes[18] = 8'h34; mem_bytes[19] = 8'h56;
    ref_mem[16]   = 8'h80; ref_mem[17]   = 8'h12; ref_mem[18]   = 8'h34; ref_mem[19]   = 8'h56;
    last_ld = 32'h0;

    rst_n = 1'b0;
    cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_funct3 = 3'd0;
    cif.req_addr = 32'h0; cif.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      {31'h0, cif.busy},  32'h0);
    chk("rst_done",      {31'h0, cif.done},  32'h0);
    chk("rst_fault",     {31'h0, cif.fault}, 32'h0);
    chk("rst_load_data", cif.load_data, 32'h0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_en",    {30'h0, mem_wr_en, mem_rd_en}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence around the preloaded word at 0x10.
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);          // LW  -> 80123456
    issue(1'b0, 3'd0, 32'h10, 32'h0, 1'b1);          // LB  -> FFFFFF80
    issue(1'b0, 3'd4, 32'h10, 32'h0, 1'b1);          // LBU -> 00000080
    issue(1'b0, 3'd1, 32'h11, 32'h0, 1'b1);          // LH  -> 00001234
    issue(1'b0, 3'd5, 32'h10, 32'h0, 1'b1);          // LHU -> 00008012
    issue(1'b1, 3'd0, 32'h12, 32'h000000AB, 1'b1);   // SB
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);          // LW  -> 8012AB56
    issue(1'b1, 3'd2, 32'h7FC, 32'hDEADBEEF, 1'b1);  // SW at top
    issue(1'b0, 3'd2, 32'h7FC, 32'h0, 1'b1);         // LW  -> DEADBEEF
    issue(1'b0, 3'd2, 32'h7FE, 32'h0, 1'b1);         // out of range -> fault
    issue(1'b1, 3'd3, 32'h10, 32'h12345678, 1'b1);   // illegal store funct3
    issue(1'b0, 3'd2, 32'h1000_0010, 32'h0, 1'b1);   // high address bits set
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    wait_idle();
    chk("preload_word", {mem_bytes[16], mem_bytes[17], mem_bytes[18], mem_bytes[19]}, 32'h8012AB56);

    // Reset during the WRITE phase of an SH: write must be abandoned.
    issue(1'b1, 3'd1, 32'h20, 32'h0000C0DE, 1'b0);
    for (k = 0; k < 10; k++) begin
      if (mem_wr_en) break;
      @(posedge clk); #1;
    end
    if (k == 10) chk("write_phase_timeout", 32'd1, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en",     {31'h0, mem_wr_en}, 32'h0);
    chk("mid_rst_rd_en",     {31'h0, mem_rd_en}, 32'h0);
    chk("mid_rst_busy",      {31'h0, cif.busy},  32'h0);
    chk("mid_rst_done",      {31'h0, cif.done},  32'h0);
    chk("mid_rst_fault",     {31'h0, cif.fault}, 32'h0);
    chk("mid_rst_load_data", cif.load_data, 32'h0);
    chk("mid_rst_mem_addr",  mem_addr,  32'h0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
    last_ld = 32'h0;
    @(posedge clk); #1;
    chk("sh_abandoned", {16'h0, mem_bytes[32], mem_bytes[33]}, {16'h0, ref_mem[32], ref_mem[33]});
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);

    // Randomized traffic, biased toward the top of memory and small range.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(2036, 2047));
        1:       a = $urandom;
        2, 3, 4: a = 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 2047));
      endcase
      issue(we, f3, a, $urandom, 1'b1);
    end

    for (k = 0; k < 20; k++) begin
      if (exq.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("pending_expected", 32'(exq.size()), 32'd0);

    bad = 0;
    for (int i = 0; i < 2048; i++)
      if (mem_bytes[i] !== ref_mem[i]) bad++;
    chk("mem_image_bad_bytes", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
